data_memory_mmio: RTL and testbench
===================================

# data_memory_mmio

Parametrised data memory with a memory-mapped peripheral window for the pipeline CPU's MEM stage. It provides word-addressed RAM with byte-lane write enables, the digital-tube display register, and a working 8N1 UART (TX, RX, status/control) at fixed MMIO addresses. Loads are combinational within the MEM cycle, and stores commit on the clock edge. It is the successor to the fixed 512-word data memory.

## Interface
Parameters:
- RAM_WORDS, 512, RAM depth in 32-bit words (power of two)
- RAM_ADDR_BITS, 9, log2(RAM_WORDS)
- MMIO_BASE, 32'h4000_0000, addresses >= this are MMIO and never reach RAM
- BAUD_DIV, 868, clk cycles per UART bit (>= 4)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- MemRead  in  1  load strobe
- MemWrite  in  1  store strobe
- MemByteEn  in  4  RAM byte-lane write enables; bit i covers Write_data[8i+7:8i]
- Address  in  32  byte address; bits [1:0] ignored
- Write_data  in  32  store data
- Read_data  out  32  load data, combinational
- tube_select  out  4  tube digit select
- tube_segment  out  8  tube segments
- uart_txd  out  1  serial out, idle high
- uart_rxd  in  1  serial in, asynchronous
- uart_irq  out  1  high while rx_valid or tx_done is set

## Operation
- Memory map:
  - 0x4000_0010 TUBE: {20'h0, tube_select, tube_segment}
  - 0x4000_0018 TXD: a write starts a transmit of Write_data[7:0]
  - 0x4000_001C RXD: {24'h0, rx_byte}
  - 0x4000_0020 CON: bit0 tx_busy, bit1 rx_valid, bit2 rx_overrun, bit3 tx_done
- RAM: Address < MMIO_BASE; index = Address[RAM_ADDR_BITS+1:2]. Higher bits are truncated, so addresses wrap modulo RAM_WORDS.
- Unmapped MMIO reads return 0, and unmapped MMIO writes are ignored. MemByteEn is ignored for MMIO; MMIO writes are always full-word.
- Read_data = 0 when MemRead=0.
- TX state machine, IDLE → START → DATA(8, LSB first) → STOP → IDLE:
  - Each bit lasts BAUD_DIV cycles.
  - A TXD write while tx_busy=1 is dropped silently.
  - Entering IDLE from STOP sets tx_done.
- RX state machine, IDLE → START → DATA → STOP:
  - uart_rxd passes through a 2-flop synchroniser.
  - IDLE waits for a synced 0, then samples at BAUD_DIV/2. If the line is high there, return to IDLE (glitch).
  - Subsequent samples are taken every BAUD_DIV cycles.
  - Stop bit 1: latch rx_byte and set rx_valid. If rx_valid was already 1, also set rx_overrun.
  - Stop bit 0: discard the frame and leave flags unchanged.
- Clearing flags:
  - A load from RXD (MemRead=1) clears rx_valid at the next edge.
  - A CON write with bit2/bit3 set clears rx_overrun/tx_done (write-1-to-clear); other CON bits are read-only.
- Simultaneous events:
  - RXD read in the same cycle a new byte completes: the new byte is latched, rx_valid stays 1, and no overrun is flagged.
  - TX completion and a tx_done clear in the same cycle: set wins.

## Timing
- Store: RAM/TUBE/CON update at the posedge where MemWrite=1.
- Load: Read_data is valid in the same cycle as Address/MemRead (zero latency).
- TXD write at edge N: tx_busy=1 and uart_txd=0 (start bit) from cycle N+1. The frame occupies 10·BAUD_DIV cycles, and tx_busy falls in the same cycle uart_txd returns high after the stop bit.
- RX: rx_valid rises about 2 + 9.5·BAUD_DIV cycles after the start-bit falling edge.
- Reset values: tube_select=0, tube_segment=0, uart_txd=1, uart_irq=0, all flags 0, rx_byte=0, both FSMs IDLE.
- RAM contents are not cleared by reset.
- Reset mid-frame aborts immediately: uart_txd=1 the cycle after reset.

## Configuration
- DMEM_UART_EN defined: UART logic and the TXD/RXD/CON registers are present as above.
- DMEM_UART_EN undefined: no UART logic. TXD/RXD/CON read 0 and writes are ignored; uart_txd is tied 1, uart_irq is tied 0, and uart_rxd is unused. RAM and TUBE are unchanged.

## Structure
- Package dmem_pkg:
  - MMIO offsets (TUBE, TXD, RXD, CON)
  - CON bit indices
  - UART state enum (IDLE, START, DATA, STOP)
- Sub-module uart_core holds both FSMs, the baud counters and the synchroniser. Interface: tx_start, tx_data, tx_busy, tx_done_pulse, rx_data, rx_done_pulse.
- Top level holds the RAM, address decode, TUBE register and flags.

## Test plan
- Store 32'hDEADBEEF to 0x0000_0008 with MemByteEn=4'b0101, then load → 32'h00AD00EF over a zeroed word. Load 0x0000_0808 with RAM_WORDS=512 → same word (wrap).
- Store 32'h0000_0A3F to 0x4000_0010 → tube_select=4'hA, tube_segment=8'h3F. Load TUBE → 32'h0000_0A3F. Store to 0x4000_0004 → ignored; loads from it read 0.
- With BAUD_DIV=8, write 8'h55 to TXD → uart_txd waveform 0,1,0,1,0,1,0,1,0,1 at 8 cycles/bit. CON bit0=1 for 80 cycles, then bit3=1 and uart_irq=1.
- Drive a frame 8'hC3 on uart_rxd → RXD reads 32'h0000_00C3 and CON bit1=1. Send a second frame without reading → CON bit2=1. Write CON=4'b1100 → bits 2 and 3 clear.
- Drive a frame with stop bit 0 → rx_valid is unchanged. Assert reset mid-TX frame → uart_txd=1 next cycle and CON reads 0.
- Build without DMEM_UART_EN → CON/RXD read 0, and a TXD write leaves uart_txd=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data memory: MMIO register offsets, UART
// control/status bit positions and the UART state encoding.
package dmem_pkg;

    localparam logic [31:0] TUBE_OFF = 32'h0000_0010;
    localparam logic [31:0] TXD_OFF  = 32'h0000_0018;
    localparam logic [31:0] RXD_OFF  = 32'h0000_001C;
    localparam logic [31:0] CON_OFF  = 32'h0000_0020;

    localparam int CON_TX_BUSY    = 0;
    localparam int CON_RX_VALID   = 1;
    localparam int CON_RX_OVERRUN = 2;
    localparam int CON_TX_DONE    = 3;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_core.sv
// 8N1 UART transmitter and receiver with per-direction baud counters and a
// two-flop input synchroniser; completion is reported as one-cycle pulses.
module uart_core #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done_pulse,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_done_pulse
);
    import dmem_pkg::*;

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

    uart_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;

    uart_state_e   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_sync1_q, rx_sync2_q;

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_bit_d      = tx_bit_q;
        tx_shift_d    = tx_shift_q;
        txd_d         = txd_q;
        tx_done_pulse = 1'b0;
        tx_cnt_d      = (tx_cnt_q == BIT_END) ? '0 : tx_cnt_q + CW'(1);
        case (tx_state_q)
            UART_IDLE: begin
                tx_cnt_d = '0;
                if (tx_start) begin
                    tx_state_d = UART_START;
                    tx_shift_d = tx_data;
                    txd_d      = 1'b0;
                end
            end
            UART_START: if (tx_cnt_q == BIT_END) begin
                tx_state_d = UART_DATA;
                tx_bit_d   = 3'd0;
                txd_d      = tx_shift_q[0];
            end
            UART_DATA: if (tx_cnt_q == BIT_END) begin
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = UART_STOP;
                    txd_d      = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    txd_d      = tx_shift_q[1];
                end
            end
            UART_STOP: if (tx_cnt_q == BIT_END) begin
                tx_state_d    = UART_IDLE;
                tx_done_pulse = 1'b1;
            end
            default: tx_state_d = UART_IDLE;
        endcase
    end

    // Receiver: a low seen in IDLE is re-checked mid start bit to reject glitches.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_done_pulse = 1'b0;
        rx_cnt_d      = (rx_cnt_q == BIT_END) ? '0 : rx_cnt_q + CW'(1);
        case (rx_state_q)
            UART_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync2_q) rx_state_d = UART_START;
            end
            UART_START: if (rx_cnt_q == HALF_END) begin
                rx_cnt_d   = '0;
                rx_bit_d   = 3'd0;
                rx_state_d = rx_sync2_q ? UART_IDLE : UART_DATA;
            end
            UART_DATA: if (rx_cnt_q == BIT_END) begin
                rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = UART_STOP;
            end
            UART_STOP: if (rx_cnt_q == BIT_END) begin
                rx_state_d    = UART_IDLE;
                rx_done_pulse = rx_sync2_q;
            end
            default: rx_state_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= UART_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= UART_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sync1_q <= rxd;
            rx_sync2_q <= rx_sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        tx_shift_q <= tx_shift_d;
        rx_shift_q <= rx_shift_d;
    end

    assign tx_busy = (tx_state_q != UART_IDLE);
    assign txd     = txd_q;
    assign rx_data = rx_shift_q;

endmodule

// File: rtl/data_memory_mmio.sv
// MEM-stage data memory: byte-lane RAM, tube register and, when DMEM_UART_EN
// is defined, an 8N1 UART with TXD/RXD/CON registers; otherwise those read 0.
module data_memory_mmio #(
    parameter int          RAM_WORDS     = 512,
    parameter int          RAM_ADDR_BITS = 9,
    parameter logic [31:0] MMIO_BASE     = 32'h4000_0000,
    parameter int          BAUD_DIV      = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [3:0]  MemByteEn,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic [3:0]  tube_select,
    output logic [7:0]  tube_segment,
    output logic        uart_txd,
    input  logic        uart_rxd,
    output logic        uart_irq
);
    import dmem_pkg::*;

    logic [31:0]              ram_q [RAM_WORDS];
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    logic [31:0]              word_addr;
    logic                     is_mmio, hit_tube, hit_rxd, hit_con;
    logic [11:0]              tube_q, tube_d;
    logic [31:0]              rxd_rdata, con_rdata;
    logic                     unused_addr_lo;

    assign ram_idx        = Address[RAM_ADDR_BITS+1:2];
    assign word_addr      = {Address[31:2], 2'b00};
    assign is_mmio        = (Address >= MMIO_BASE);
    assign hit_tube       = is_mmio && (word_addr == MMIO_BASE + TUBE_OFF);
    assign hit_rxd        = is_mmio && (word_addr == MMIO_BASE + RXD_OFF);
    assign hit_con        = is_mmio && (word_addr == MMIO_BASE + CON_OFF);
    assign unused_addr_lo = ^Address[1:0];

    // RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (MemWrite && !is_mmio && MemByteEn[i])
                ram_q[ram_idx][8*i +: 8] <= Write_data[8*i +: 8];
        end
    end

    always_comb begin
        tube_d = tube_q;
        if (MemWrite && hit_tube) tube_d = Write_data[11:0];
    end

    always_ff @(posedge clk) begin
        if (reset) tube_q <= '0;
        else       tube_q <= tube_d;
    end

    assign tube_select  = tube_q[11:8];
    assign tube_segment = tube_q[7:0];

`ifdef DMEM_UART_EN
    logic       hit_txd, rd_rxd, wr_con;
    logic       tx_busy, tx_done_pulse, rx_done_pulse;
    logic [7:0] rx_data;
    logic       rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, tx_done_q, tx_done_d;
    logic [7:0] rx_byte_q, rx_byte_d;

    assign hit_txd = is_mmio && (word_addr == MMIO_BASE + TXD_OFF);
    assign rd_rxd  = MemRead && hit_rxd;
    assign wr_con  = MemWrite && hit_con;

    uart_core #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk           (clk),
        .reset         (reset),
        .tx_start      (MemWrite && hit_txd && !tx_busy),
        .tx_data       (Write_data[7:0]),
        .tx_busy       (tx_busy),
        .tx_done_pulse (tx_done_pulse),
        .txd           (uart_txd),
        .rxd           (uart_rxd),
        .rx_data       (rx_data),
        .rx_done_pulse (rx_done_pulse)
    );

    // Completion events are applied after the clears so that a set always wins.
    always_comb begin
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        tx_done_d    = tx_done_q;
        rx_byte_d    = rx_byte_q;
        if (rd_rxd) rx_valid_d = 1'b0;
        if (wr_con && Write_data[CON_RX_OVERRUN]) rx_overrun_d = 1'b0;
        if (wr_con && Write_data[CON_TX_DONE])    tx_done_d    = 1'b0;
        if (tx_done_pulse) tx_done_d = 1'b1;
        if (rx_done_pulse) begin
            rx_byte_d  = rx_data;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rd_rxd) rx_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            tx_done_q    <= 1'b0;
            rx_byte_q    <= '0;
        end else begin
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            tx_done_q    <= tx_done_d;
            rx_byte_q    <= rx_byte_d;
        end
    end

    always_comb begin
        con_rdata                 = '0;
        con_rdata[CON_TX_BUSY]    = tx_busy;
        con_rdata[CON_RX_VALID]   = rx_valid_q;
        con_rdata[CON_RX_OVERRUN] = rx_overrun_q;
        con_rdata[CON_TX_DONE]    = tx_done_q;
    end

    assign rxd_rdata = {24'h0, rx_byte_q};
    assign uart_irq  = rx_valid_q | tx_done_q;
`else
    logic unused_uart_rxd;

    assign unused_uart_rxd = uart_rxd;
    assign con_rdata       = '0;
    assign rxd_rdata       = '0;
    assign uart_txd        = 1'b1;
    assign uart_irq        = 1'b0;
`endif

    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            if (!is_mmio)      Read_data = ram_q[ram_idx];
            else if (hit_tube) Read_data = {20'h0, tube_q};
            else if (hit_rxd)  Read_data = rxd_rdata;
            else if (hit_con)  Read_data = con_rdata;
        end
    end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Randomised bench for data_memory_mmio against a cycle-count based model;
// covers both builds (DMEM_UART_EN defined or not).
module tb_data_memory_mmio;
    localparam int BD = 8;
    localparam int RW = 512;
    localparam logic [31:0] MMIO   = 32'h4000_0000;
    localparam logic [31:0] A_TUBE = 32'h4000_0010;
    localparam logic [31:0] A_TXD  = 32'h4000_0018;
    localparam logic [31:0] A_RXD  = 32'h4000_001C;
    localparam logic [31:0] A_CON  = 32'h4000_0020;
`ifdef DMEM_UART_EN
    localparam bit UART_EN = 1'b1;
`else
    localparam bit UART_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, MemRead, MemWrite, uart_rxd;
    logic [3:0]  MemByteEn;
    logic [31:0] Address, Write_data, Read_data;
    logic [3:0]  tube_select;
    logic [7:0]  tube_segment;
    logic        uart_txd, uart_irq;

    always #5 clk = ~clk;

    data_memory_mmio #(
        .RAM_WORDS(RW), .RAM_ADDR_BITS(9), .MMIO_BASE(MMIO), .BAUD_DIV(BD)
    ) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemByteEn(MemByteEn), .Address(Address), .Write_data(Write_data),
        .Read_data(Read_data), .tube_select(tube_select), .tube_segment(tube_segment),
        .uart_txd(uart_txd), .uart_rxd(uart_rxd), .uart_irq(uart_irq)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [RW];
    bit          m_known [RW];
    logic [11:0] m_tube = '0;
    int          cyc_n = 0;
    bit          tx_active = 1'b0;
    int          tx_t0 = 0;
    logic [7:0]  tx_byte = '0;
    bit          m_tx_done = 1'b0, m_rx_valid = 1'b0, m_rx_over = 1'b0;
    logic [7:0]  m_rx_byte = '0;
    int          rx_start_cnt = 0, rx_req_cnt = 0, rx_ack_cnt = 0;
    logic [7:0]  rx_req_byte = '0;
    bit          rx_req_good = 1'b0;
    bit          run_cmp = 1'b0;

    // Transmit line as a function of cycles elapsed since the accepting edge.
    function automatic logic exp_txd();
        int k, b;
        if (!tx_active) return 1'b1;
        k = cyc_n - tx_t0;
        b = k / BD;
        if (b == 0) return 1'b0;
        if (b <= 8) return tx_byte[b-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_con();
        return UART_EN ? {28'h0, m_tx_done, m_rx_over, m_rx_valid, tx_active} : 32'h0;
    endfunction

    function automatic bit exp_read(output logic [31:0] v);
        logic [31:0] wa;
        logic [8:0]  idx;
        wa = {Address[31:2], 2'b00};
        v = '0;
        if (!MemRead) return 1'b1;
        if (Address < MMIO) begin
            idx = Address[10:2];
            v = m_ram[idx];
            return m_known[idx];
        end
        case (wa)
            A_TUBE:  v = {20'h0, m_tube};
            A_RXD:   v = UART_EN ? {24'h0, m_rx_byte} : 32'h0;
            A_CON:   v = exp_con();
            default: v = '0;
        endcase
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc_n++;
        if (reset) begin
            m_tube = '0; tx_active = 0; m_tx_done = 0; m_rx_valid = 0; m_rx_over = 0;
            m_rx_byte = '0; rx_ack_cnt = rx_req_cnt;
        end else begin
            bit busy_pre, done_set;
            logic [31:0] wa;
            logic [8:0] idx;
            busy_pre = tx_active;
            done_set = 0;
            wa = {Address[31:2], 2'b00};
            if (tx_active && (cyc_n - tx_t0 == 10*BD)) begin
                tx_active = 0;
                done_set = 1;
            end
            if (MemWrite) begin
                if (Address < MMIO) begin
                    idx = Address[10:2];
                    for (int i = 0; i < 4; i++)
                        if (MemByteEn[i]) m_ram[idx][8*i +: 8] = Write_data[8*i +: 8];
                    m_known[idx] = m_known[idx] || (MemByteEn == 4'hF);
                end else if (wa == A_TUBE) begin
                    m_tube = Write_data[11:0];
                end else if (UART_EN && wa == A_TXD && !busy_pre) begin
                    tx_active = 1; tx_t0 = cyc_n; tx_byte = Write_data[7:0];
                end else if (UART_EN && wa == A_CON) begin
                    if (Write_data[2]) m_rx_over = 0;
                    if (Write_data[3]) m_tx_done = 0;
                end
            end
            if (done_set) m_tx_done = 1;
            if (UART_EN && MemRead && wa == A_RXD) m_rx_valid = 0;
            if (rx_ack_cnt != rx_req_cnt) begin
                if (UART_EN && rx_req_good) begin
                    if (m_rx_valid) m_rx_over = 1;
                    m_rx_valid = 1;
                    m_rx_byte = rx_req_byte;
                end
                rx_ack_cnt = rx_req_cnt;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (run_cmp) begin
            logic [31:0] ev;
            bit kn;
            kn = exp_read(ev);
            if (kn) check("read_data", Read_data, ev);
            check("tube", {20'h0, tube_select, tube_segment}, {20'h0, m_tube});
            check("uart_txd", {31'h0, uart_txd}, {31'h0, exp_txd()});
            if (rx_start_cnt == rx_ack_cnt)
                check("uart_irq", {31'h0, uart_irq}, {31'h0, m_tx_done | m_rx_valid});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        Address = a; Write_data = d; MemByteEn = be; MemWrite = 1; MemRead = 0;
        @(posedge clk); #1;
        MemWrite = 0;
    endtask

    task automatic rd(input logic [31:0] a);
        Address = a; MemRead = 1;
        @(posedge clk); #1;
        MemRead = 0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
        Address = a; MemRead = 1;
        @(negedge clk);
        check(nm, Read_data, exp);
        @(posedge clk); #1;
        MemRead = 0;
    endtask

    task automatic rand_op();
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2, 3: wr($urandom & 32'h1FFF, $urandom, 4'($urandom));
            4, 5, 6:    rd($urandom & 32'h1FFF);
            7: if ($urandom_range(0, 1) == 1) wr(A_TUBE, $urandom, 4'($urandom));
               else rd(A_TUBE);
            8: begin
                a = MMIO + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) wr(a, $urandom, 4'($urandom));
                else rd(a);
            end
            default: idle(1);
        endcase
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stopb);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        rx_start_cnt++;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = fr[i];
            idle(BD);
        end
        uart_rxd = 1'b1;
        rx_req_byte = b;
        rx_req_good = stopb;
        rx_req_cnt++;
        idle(2*BD);
    endtask

    task automatic wait_tx_idle();
        int t;
        t = 0;
        while (tx_active && t < 20*BD) begin idle(1); t++; end
        check("tx_idle_wait", {31'h0, tx_active}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        logic [9:0] pat;
        reset = 1; MemRead = 0; MemWrite = 0; MemByteEn = 0;
        Address = 0; Write_data = 0; uart_rxd = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        run_cmp = 1;

        @(negedge clk);
        check("rst_tube", {20'h0, tube_select, tube_segment}, 32'h0);
        check("rst_txd", {31'h0, uart_txd}, 32'h1);
        check("rst_irq", {31'h0, uart_irq}, 32'h0);
        @(posedge clk); #1;
        rd_chk(A_CON, 32'h0, "rst_con");
        rd_chk(A_RXD, 32'h0, "rst_rxd");

        wr(32'h8, 32'h0, 4'hF);
        wr(32'h8, 32'hDEADBEEF, 4'b0101);
        rd_chk(32'h8, 32'h00AD00EF, "ram_byte_en");
        rd_chk(32'h808, 32'h00AD00EF, "ram_wrap");
        Address = 32'h8; MemRead = 0;
        @(negedge clk);
        check("no_read_zero", Read_data, 32'h0);
        @(posedge clk); #1;

        wr(A_TUBE, 32'h0000_0A3F, 4'h0);
        @(negedge clk);
        check("tube_select", {28'h0, tube_select}, 32'hA);
        check("tube_segment", {24'h0, tube_segment}, 32'h3F);
        @(posedge clk); #1;
        rd_chk(A_TUBE, 32'h0000_0A3F, "tube_read");
        wr(32'h4000_0004, 32'hFFFF_FFFF, 4'hF);
        rd_chk(32'h4000_0004, 32'h0, "unmapped_read");

        repeat (400) rand_op();

`ifdef DMEM_UART_EN
        wait_tx_idle();
        wr(A_CON, 32'hC, 4'hF);
        pat = 10'b1010101010;
        wr(A_TXD, 32'h55, 4'hF);
        Address = A_CON; MemRead = 1;
        for (int k = 0; k <= 10*BD; k++) begin
            @(negedge clk);
            if (k < 10*BD && (k % BD) == BD/2)
                check($sformatf("tx55_bit%0d", k/BD), {31'h0, uart_txd}, {31'h0, pat[k/BD]});
            if (k == 0 || k == 10*BD-1) check("tx_busy_con", Read_data, 32'h1);
            if (k == 10*BD) begin
                check("tx_done_con", Read_data, 32'h8);
                check("tx_done_irq", {31'h0, uart_irq}, 32'h1);
            end
        end
        @(posedge clk); #1;
        MemRead = 0;
        wr(A_CON, 32'hC, 4'hF);
        rd_chk(A_CON, 32'h0, "con_w1c_done");

        send_rx(8'hC3, 1'b1);
        rd_chk(A_CON, 32'h2, "rx_valid");
        rd_chk(A_RXD, 32'hC3, "rx_byte_c3");
        rd_chk(A_CON, 32'h0, "rxd_read_clears");
        send_rx(8'h5A, 1'b1);
        send_rx(8'h96, 1'b1);
        rd_chk(A_CON, 32'h6, "rx_overrun");
        rd_chk(A_RXD, 32'h96, "rx_byte_latest");
        wr(A_CON, 32'hC, 4'hF);
        rd_chk(A_CON, 32'h0, "con_w1c_overrun");
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b0);
        rd_chk(A_CON, 32'h2, "bad_stop_flags");
        rd_chk(A_RXD, 32'h11, "bad_stop_byte");

        wr(A_TXD, 32'hA5, 4'hF);
        idle(30);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("reset_mid_tx_txd", {31'h0, uart_txd}, 32'h1);
        @(posedge clk); #1;
        rd_chk(A_CON, 32'h0, "reset_mid_tx_con");

        for (int n = 0; n < 6; n++) begin
            wait_tx_idle();
            wr(A_TXD, $urandom, 4'hF);
            repeat (40) rand_op();
            send_rx(8'($urandom), $urandom_range(0, 3) != 0);
            repeat (20) rand_op();
        end
`else
        wr(A_TXD, 32'h55, 4'hF);
        idle(3);
        @(negedge clk);
        check("noua_txd", {31'h0, uart_txd}, 32'h1);
        @(posedge clk); #1;
        rd_chk(A_CON, 32'h0, "noua_con");
        send_rx(8'hC3, 1'b1);
        rd_chk(A_CON, 32'h0, "noua_con_after_rx");
        rd_chk(A_RXD, 32'h0, "noua_rxd");
        @(negedge clk);
        check("noua_irq", {31'h0, uart_irq}, 32'h0);
        @(posedge clk); #1;
`endif

        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
